// File: rtl/plic_pkg.sv
// Definitions shared between the PLIC target and its hart-side claim handler.
package plic_pkg;

    localparam logic [5:0] CLAIMCOMP_OFFSET = 6'h1C;
    localparam int         PLIC_ID_WIDTH    = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_SETUP,
        ST_RD_ACCESS,
        ST_DELIVER,
        ST_SERVICE,
        ST_WR_SETUP,
        ST_WR_ACCESS,
        ST_HOLD
    } claim_state_e;

endpackage

// File: rtl/apb4_master_xfer.sv
// Single APB4 SETUP/ACCESS transfer engine with an access-phase timeout.
// Handshake: req_i is held high from the setup cycle until the cycle done_o=1; err_o qualifies done_o.
module apb4_master_xfer #(
    parameter int TIMEOUT = 255
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        req_i,
    input  logic        write_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  strb_i,
    output logic        done_o,
    output logic        err_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] paddr_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic        pready_i,
    input  logic        pslverr_i
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic          access_q, access_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout;

    always_comb begin
        timeout   = (TIMEOUT != 0) && access_q && !pready_i && (cnt_q == CW'(TIMEOUT - 1));
        done_o    = access_q && (pready_i || timeout);
        err_o     = access_q && ((pready_i && pslverr_i) || timeout);
        access_d  = access_q ? !done_o : req_i;
        cnt_d     = '0;
        // Counter only advances inside the access phase; entry always starts from zero.
        if (access_q && !done_o && (TIMEOUT != 0)) begin
            cnt_d = cnt_q + CW'(1);
        end
        psel_o    = req_i;
        penable_o = req_i && access_q;
        pwrite_o  = req_i && write_i;
        paddr_o   = req_i ? addr_i : '0;
        pwdata_o  = (req_i && write_i) ? wdata_i : '0;
        pstrb_o   = (req_i && write_i) ? strb_i : '0;
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            access_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            access_q <= access_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/apb4_plic_claimer.sv
// Hart-side PLIC handler: claims an ID over APB4, hands it to the core,
// and writes it back to claim/complete once the core signals completion.
module apb4_plic_claimer
    import plic_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0,
    parameter logic [5:0]  CLAIM_OFFSET = CLAIMCOMP_OFFSET,
    parameter int          ID_WIDTH     = PLIC_ID_WIDTH,
    parameter int          TIMEOUT      = 255,
    parameter int          HOLDOFF      = 4
) (
    input  logic                pclk,
    input  logic                presetn,
    input  logic                ext_irq_i,
    output logic [31:0]         paddr_o,
    output logic                psel_o,
    output logic                penable_o,
    output logic                pwrite_o,
    output logic [31:0]         pwdata_o,
    output logic [3:0]          pstrb_o,
    output logic [2:0]          pprot_o,
    input  logic [31:0]         prdata_i,
    input  logic                pready_i,
    input  logic                pslverr_i,
    output logic                irq_vld_o,
    output logic [ID_WIDTH-1:0] irq_id_o,
    input  logic                irq_rdy_i,
    input  logic                comp_i,
    output logic                busy_o,
    output logic                err_o
);

    localparam int          HW         = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [31:0] CLAIM_ADDR = BASE_ADDR + {26'd0, CLAIM_OFFSET};

    claim_state_e        state_q, state_d;
    logic [ID_WIDTH-1:0] id_q, id_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                err_q;

    logic                x_req, x_write, x_done, x_err;
    logic [ID_WIDTH-1:0] rd_id;
    logic                unused_rdata;

    assign rd_id        = prdata_i[ID_WIDTH-1:0];
    assign unused_rdata = ^prdata_i[31:ID_WIDTH];

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        hold_d  = hold_q;
        x_req   = 1'b0;
        x_write = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ext_irq_i) state_d = ST_RD_SETUP;
            end
            ST_RD_SETUP: begin
                x_req   = 1'b1;
                state_d = ST_RD_ACCESS;
            end
            ST_RD_ACCESS: begin
                x_req = 1'b1;
                if (x_done) begin
                    if (x_err) begin
                        state_d = ST_IDLE;
                    end else if (rd_id == '0) begin
                        hold_d  = '0;
                        state_d = (HOLDOFF == 0) ? ST_IDLE : ST_HOLD;
                    end else begin
                        id_d    = rd_id;
                        state_d = ST_DELIVER;
                    end
                end
            end
            ST_DELIVER: begin
                if (irq_rdy_i) state_d = ST_SERVICE;
            end
            ST_SERVICE: begin
                if (comp_i) state_d = ST_WR_SETUP;
            end
            ST_WR_SETUP: begin
                x_req   = 1'b1;
                x_write = 1'b1;
                state_d = ST_WR_ACCESS;
            end
            ST_WR_ACCESS: begin
                x_req   = 1'b1;
                x_write = 1'b1;
                // Error or not, the ID is retired; nothing is retried.
                if (x_done) state_d = ST_IDLE;
            end
            ST_HOLD: begin
                if (hold_q == HW'(HOLDOFF - 1)) state_d = ST_IDLE;
                else                            hold_d  = hold_q + HW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            hold_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            hold_q  <= hold_d;
            err_q   <= x_done && x_err;
        end
    end

    apb4_master_xfer #(
        .TIMEOUT (TIMEOUT)
    ) u_xfer (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_i     (x_req),
        .write_i   (x_write),
        .addr_i    (CLAIM_ADDR),
        .wdata_i   ({{(32-ID_WIDTH){1'b0}}, id_q}),
        .strb_i    (4'hF),
        .done_o    (x_done),
        .err_o     (x_err),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .paddr_o   (paddr_o),
        .pwdata_o  (pwdata_o),
        .pstrb_o   (pstrb_o),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i)
    );

    assign pprot_o   = 3'b000;
    assign irq_vld_o = (state_q == ST_DELIVER);
    assign irq_id_o  = irq_vld_o ? id_q : '0;
    assign busy_o    = (state_q != ST_IDLE);
    assign err_o     = err_q;

endmodule

// File: tb/tb_apb4_plic_claimer.sv
// Directed bench for apb4_plic_claimer with a reactive APB slave and a transfer scoreboard.
module tb_apb4_plic_claimer;

    localparam logic [31:0] CLAIM_ADDR = 32'h0000_001C;

    logic        pclk, presetn, ext_irq_i;
    logic [31:0] paddr_o, pwdata_o, prdata_i;
    logic        psel_o, penable_o, pwrite_o, pready_i, pslverr_i;
    logic [3:0]  pstrb_o;
    logic [2:0]  pprot_o;
    logic        irq_vld_o, irq_rdy_i, comp_i, busy_o, err_o;
    logic [4:0]  irq_id_o;

    int errors = 0;
    int checks = 0;

    // scoreboard of expected APB transfers: {pwrite, paddr, pwdata, pstrb, pprot}
    logic [71:0] exp_q[$];

    // slave configuration and monitor statistics
    int          slv_wait = 0;
    logic [31:0] slv_rdata = '0;
    logic        slv_err = 1'b0;
    int          acc_len = 0, last_acc_len = 0;
    int          cyc = 0, cmpl_n = 0, last_cmpl = 0, prev_cmpl = 0;
    int          vld_cycles = 0, err_cycles = 0;

    apb4_plic_claimer dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .ext_irq_i (ext_irq_i),
        .paddr_o   (paddr_o),
        .psel_o    (psel_o),
        .penable_o (penable_o),
        .pwrite_o  (pwrite_o),
        .pwdata_o  (pwdata_o),
        .pstrb_o   (pstrb_o),
        .pprot_o   (pprot_o),
        .prdata_i  (prdata_i),
        .pready_i  (pready_i),
        .pslverr_i (pslverr_i),
        .irq_vld_o (irq_vld_o),
        .irq_id_o  (irq_id_o),
        .irq_rdy_i (irq_rdy_i),
        .comp_i    (comp_i),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] xfer_exp(input logic w, input logic [31:0] d);
        return {w, CLAIM_ADDR, (w ? d : 32'h0), (w ? 4'hF : 4'h0), 3'b000};
    endfunction

    function automatic logic [95:0] all_outs();
        return {14'h0, paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o, pprot_o,
                irq_vld_o, irq_id_o, busy_o, err_o};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(negedge pclk);
            #1;
        end
    endtask

    task automatic wait_vld(input string tag);
        int n = 0;
        while (!irq_vld_o && n < 100) begin
            step(1);
            n++;
        end
        check(tag, 96'(irq_vld_o), 96'(1));
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy_o && n < 100) begin
            step(1);
            n++;
        end
        check(tag, 96'(busy_o), 96'(0));
    endtask

    task automatic accept_and_complete();
        irq_rdy_i = 1'b1;
        step(1);
        irq_rdy_i = 1'b0;
        step(2);
        comp_i = 1'b1;
        step(1);
        comp_i = 1'b0;
    endtask

    // APB slave responder and transfer monitor, evaluated on the falling edge
    initial begin
        pready_i  = 1'b0;
        prdata_i  = '0;
        pslverr_i = 1'b0;
        forever begin
            @(negedge pclk);
            cyc++;
            if (irq_vld_o) vld_cycles++;
            if (err_o)     err_cycles++;
            if (psel_o && penable_o) begin
                if (acc_len >= slv_wait) begin
                    pready_i  = 1'b1;
                    prdata_i  = slv_rdata;
                    pslverr_i = slv_err;
                end else begin
                    pready_i  = 1'b0;
                    prdata_i  = '0;
                    pslverr_i = 1'b0;
                end
                acc_len++;
                if (pready_i) begin
                    check("xfer_expected", 96'(exp_q.size() != 0), 96'(1));
                    if (exp_q.size() != 0) begin
                        check("xfer_fields",
                              96'({pwrite_o, paddr_o, (pwrite_o ? pwdata_o : 32'h0), pstrb_o, pprot_o}),
                              96'(exp_q.pop_front()));
                    end
                    prev_cmpl = last_cmpl;
                    last_cmpl = cyc;
                    cmpl_n++;
                end
            end else begin
                pready_i  = 1'b0;
                prdata_i  = '0;
                pslverr_i = 1'b0;
                if (acc_len != 0) last_acc_len = acc_len;
                acc_len = 0;
            end
        end
    end

    initial begin
        int n, n0, e0, v0;
        logic stable;
        presetn   = 1'b0;
        ext_irq_i = 1'b0;
        irq_rdy_i = 1'b0;
        comp_i    = 1'b0;
        step(3);
        check("reset_outs", all_outs(), 96'h0);
        presetn = 1'b1;
        step(2);

        // normal claim / deliver / complete of ID 5
        slv_rdata = 32'h0000_0005;
        exp_q.push_back(xfer_exp(1'b0, 32'h0));
        exp_q.push_back(xfer_exp(1'b1, 32'h5));
        ext_irq_i = 1'b1;
        wait_vld("t1_vld_seen");
        check("t1_id", 96'(irq_id_o), 96'(5));
        ext_irq_i = 1'b0;
        irq_rdy_i = 1'b1;
        step(1);
        irq_rdy_i = 1'b0;
        step(4);
        check("t1_wr_pending", 96'(exp_q.size()), 96'(1));
        check("t1_busy_service", 96'(busy_o), 96'(1));
        comp_i = 1'b1;
        step(1);
        comp_i = 1'b0;
        wait_idle("t1_idle");
        check("t1_sb_empty", 96'(exp_q.size()), 96'(0));

        // spurious claim (upper bits set, ID field 0), holdoff, then re-claim of ID 9
        slv_rdata = 32'hFFFF_FFE0;
        exp_q.push_back(xfer_exp(1'b0, 32'h0));
        exp_q.push_back(xfer_exp(1'b0, 32'h0));
        exp_q.push_back(xfer_exp(1'b1, 32'h9));
        n0 = cmpl_n;
        ext_irq_i = 1'b1;
        n = 0;
        while (cmpl_n == n0 && n < 50) begin
            step(1);
            n++;
        end
        slv_rdata = 32'h1234_5609;
        wait_vld("t2_vld_seen");
        check("t2_id", 96'(irq_id_o), 96'(9));
        check("t2_reclaim_gap", 96'(last_cmpl - prev_cmpl), 96'(7));
        ext_irq_i = 1'b0;
        accept_and_complete();
        wait_idle("t2_idle");
        check("t2_sb_empty", 96'(exp_q.size()), 96'(0));

        // pready never arrives: timeout after 255 access cycles
        slv_wait = 1000;
        e0 = err_cycles;
        ext_irq_i = 1'b1;
        n = 0;
        while (!psel_o && n < 20) begin
            step(1);
            n++;
        end
        ext_irq_i = 1'b0;
        n = 0;
        while (!err_o && n < 400) begin
            step(1);
            n++;
        end
        check("t3_err_seen", 96'(err_o), 96'(1));
        step(3);
        check("t3_access_len", 96'(last_acc_len), 96'(255));
        check("t3_err_cycles", 96'(err_cycles - e0), 96'(1));
        check("t3_idle", 96'({psel_o, busy_o}), 96'(0));
        slv_wait = 0;

        // slave error on the claim read: no delivery, no write-back
        slv_err   = 1'b1;
        slv_rdata = 32'h0000_0007;
        exp_q.push_back(xfer_exp(1'b0, 32'h0));
        v0 = vld_cycles;
        e0 = err_cycles;
        ext_irq_i = 1'b1;
        n = 0;
        while (!err_o && n < 50) begin
            step(1);
            n++;
        end
        ext_irq_i = 1'b0;
        step(20);
        check("t4_no_vld", 96'(vld_cycles - v0), 96'(0));
        check("t4_err_cycles", 96'(err_cycles - e0), 96'(1));
        check("t4_sb_empty", 96'(exp_q.size()), 96'(0));
        check("t4_idle", 96'(busy_o), 96'(0));
        slv_err = 1'b0;

        // slow accept, early comp during DELIVER, ext_irq toggling
        slv_rdata = 32'h0000_0003;
        exp_q.push_back(xfer_exp(1'b0, 32'h0));
        exp_q.push_back(xfer_exp(1'b1, 32'h3));
        ext_irq_i = 1'b1;
        wait_vld("t5_vld_seen");
        comp_i    = 1'b1;
        ext_irq_i = 1'b0;
        step(1);
        comp_i = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!(irq_vld_o === 1'b1 && irq_id_o === 5'd3)) stable = 1'b0;
            ext_irq_i = ~ext_irq_i;
            step(1);
        end
        ext_irq_i = 1'b0;
        check("t5_id_stable", 96'(stable), 96'(1));
        irq_rdy_i = 1'b1;
        step(1);
        irq_rdy_i = 1'b0;
        step(5);
        check("t5_early_comp_ignored", 96'(exp_q.size()), 96'(1));
        check("t5_busy_service", 96'(busy_o), 96'(1));
        comp_i = 1'b1;
        step(1);
        comp_i = 1'b0;
        wait_idle("t5_idle");
        check("t5_sb_empty", 96'(exp_q.size()), 96'(0));

        // reset in the middle of the claim read, then a fresh claim of ID 11
        slv_wait  = 1000;
        ext_irq_i = 1'b1;
        n = 0;
        while (!(psel_o && penable_o) && n < 20) begin
            step(1);
            n++;
        end
        step(3);
        presetn = 1'b0;
        #1;
        check("t6_reset_outs", all_outs(), 96'h0);
        step(2);
        slv_wait  = 0;
        slv_rdata = 32'h0000_000B;
        exp_q.push_back(xfer_exp(1'b0, 32'h0));
        exp_q.push_back(xfer_exp(1'b1, 32'hB));
        presetn = 1'b1;
        wait_vld("t6_vld_seen");
        check("t6_id", 96'(irq_id_o), 96'(11));
        ext_irq_i = 1'b0;
        accept_and_complete();
        wait_idle("t6_idle");
        check("t6_sb_empty", 96'(exp_q.size()), 96'(0));

        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/apb4_plic_claimer.md
Name: apb4_plic_claimer

Overview:
- APB4 initiator that serves as the hart-side handler for the PLIC target context.
- When ext_irq is asserted, it reads the claim/complete register to claim the highest-priority ID.
- It hands that ID to the core over a valid/ready handshake, waits for the core's completion pulse, then writes the same ID back to the claim/complete register.
- It sits between the PLIC's APB4 slave port (via the bus fabric) and the core's external-interrupt input.

Parameters:
- BASE_ADDR, 32'h0, base address of the PLIC register block.
- CLAIM_OFFSET, 6'h1C, byte offset of the claim/complete register (word index 7).
- ID_WIDTH, 5, width of an interrupt ID; IDs 1..31 are valid, 0 means none.
- TIMEOUT, 255, maximum number of access-phase cycles to wait for pready; 0 disables the timeout.
- HOLDOFF, 4, idle cycles enforced after a spurious (ID 0) claim before ext_irq is re-sampled.

Ports:
- pclk  in  1  clock
- presetn  in  1  asynchronous active-low reset
- ext_irq_i  in  1  level interrupt from the PLIC (max-priority pending ID > threshold)
- paddr_o  out  32  APB address
- psel_o  out  1  APB select
- penable_o  out  1  APB enable
- pwrite_o  out  1  APB write
- pwdata_o  out  32  APB write data
- pstrb_o  out  4  APB write strobe
- pprot_o  out  3  APB protection, fixed 3'b000
- prdata_i  in  32  APB read data
- pready_i  in  1  APB ready
- pslverr_i  in  1  APB slave error
- irq_vld_o  out  1  claimed ID valid to the core
- irq_id_o  out  ID_WIDTH  claimed ID
- irq_rdy_i  in  1  core accepts the ID
- comp_i  in  1  one-cycle pulse: core finished servicing the ID
- busy_o  out  1  any state other than IDLE
- err_o  out  1  one-cycle pulse on pslverr or timeout

Behaviour:
- Clock and reset: single clock pclk; presetn is asynchronous, active-low. Reset clears every flop.
- Reset values: all outputs 0, state IDLE, ID register 0, counters 0.
- FSM states: IDLE, RD_SETUP, RD_ACCESS, DELIVER, SERVICE, WR_SETUP, WR_ACCESS, HOLD.
- IDLE: go to RD_SETUP when ext_irq_i=1 (registered decision, one cycle latency).
- RD_SETUP (one cycle):
  - psel=1, penable=0, pwrite=0, paddr=BASE_ADDR+CLAIM_OFFSET, pstrb=0.
  - Then go to RD_ACCESS.
- RD_ACCESS: psel=1, penable=1, all address/control held stable until pready_i=1.
- RD_ACCESS completion (cycle with pready_i=1):
  - If pslverr_i: pulse err_o, go to IDLE.
  - Else if prdata_i[ID_WIDTH-1:0]==0 (spurious): go to HOLD.
  - Else capture the ID and go to DELIVER.
  - Bits of prdata_i above ID_WIDTH are ignored.
- DELIVER:
  - irq_vld_o=1 with irq_id_o stable until irq_rdy_i=1, then go to SERVICE.
  - irq_vld_o must not drop before acceptance.
- SERVICE: wait for comp_i, then go to WR_SETUP. comp_i in any other state is ignored.
- WR_SETUP / WR_ACCESS:
  - Same phasing as the read, with pwrite=1, pwdata={zero-extend, ID}, pstrb=4'hF.
  - Completion: pslverr pulses err_o.
  - Both completion and error go to IDLE; the ID is considered retired either way.
- HOLD: count HOLDOFF cycles, then go to IDLE. HOLDOFF=0 returns to IDLE immediately.
- Timeout:
  - The wait counter runs only in *_ACCESS states and resets on entry.
  - If it reaches TIMEOUT with pready_i still 0: drop psel/penable, pulse err_o, go to IDLE.
  - An ID already claimed but not written back stays in the PLIC; there is no retry.
- ext_irq_i deasserting in any non-IDLE state does not abort the sequence. The claim already in flight decides the outcome.
- Back-to-back interrupts: after WR_ACCESS returns to IDLE, a still-high ext_irq_i starts a new claim on the next cycle. Minimum gap between transfers is 1 idle cycle.
- Only one transfer is ever outstanding. paddr/pwrite/pwdata are driven 0 outside SETUP/ACCESS.
- busy_o = (state != IDLE).

Decomposition:
- Shared package plic_pkg (shared with the PLIC slave): CLAIMCOMP offset, ID width, and an FSM state enum typedef.
- One natural sub-module: apb4_master_xfer. It runs a single SETUP/ACCESS transfer with the timeout counter and exposes a req/done/err handshake. The claimer FSM instantiates it once and reuses it for both the read and the write.

Test Plan:
- ext_irq=1, slave returns prdata=5 with pready on the first access cycle -> read to 0x1C, irq_vld/irq_id=5. After irq_rdy then comp_i, a write to 0x1C with pwdata=5, pstrb=F, then IDLE.
- Claim returns 0 with HOLDOFF=4 -> no irq_vld, 4 HOLD cycles, then re-claim if ext_irq is still 1.
- pready held low for 300 cycles with TIMEOUT=255 -> psel drops after 255 access cycles, err_o pulses for exactly one cycle, state IDLE.
- pslverr=1 on the claim read -> err_o pulse, no delivery, no write.
- irq_rdy delayed 10 cycles, comp_i pulsed during DELIVER and ext_irq toggling -> irq_id stable, early comp ignored, write only after comp in SERVICE.
- presetn asserted mid-RD_ACCESS -> all outputs 0 immediately. After release, a fresh RD_SETUP when ext_irq=1.
